// File: rtl/div_operand_queue.sv
// div_operand_queue: first-word-fall-through operand FIFO in front of the signed
// divider. Each pair is tagged with divide-by-zero and overflow flags at enqueue.
// Optional build macro: DIV_ZERO_DROP_EN -- zero-divisor pairs are accepted but
// discarded (still counted in err_cnt); out_dz then always reads 0.
module div_operand_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_dividend,
   input  logic [W-1:0]             in_divisor,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_dividend,
   output logic [W-1:0]             out_divisor,
   output logic                     out_dz,
   output logic                     out_ovf,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               err_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [W-1:0] dividend;
      logic [W-1:0] divisor;
      logic         dz;
      logic         ovf;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   entry_t        wr_entry;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          in_zero;
   logic          in_ovf;
   logic          push_hs;
   logic          pop_hs;
   logic          wr_en;

   // Enqueue-time flag generation, handshake decode and write qualification
   always_comb begin
      in_zero  = (in_divisor == '0);
      in_ovf   = (in_dividend == {1'b1, {(W-1){1'b0}}}) && (in_divisor == '1);
      in_ready = (count != CW'(DEPTH));
      out_valid = (count != '0);
      push_hs  = in_valid && in_ready;
      pop_hs   = out_valid && out_ready;
      wr_entry.dividend = in_dividend;
      wr_entry.divisor  = in_divisor;
      wr_entry.ovf      = in_ovf;
`ifdef DIV_ZERO_DROP_EN
      // zero-divisor pairs are never stored, so the stored dz bit is always 0
      wr_entry.dz = 1'b0;
      wr_en       = push_hs && !in_zero;
`else
      wr_entry.dz = in_zero;
      wr_en       = push_hs;
`endif
   end

   // Entry storage; cleared on reset so the masked head never exposes stale data
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointers and occupancy; full/empty are taken from count, pointers wrap freely
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_hs) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(wr_en) - CW'(pop_hs);
      end
   end

   // Saturating count of accepted zero-divisor pairs (dropped or not)
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (push_hs && in_zero && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

   // Head presentation straight from storage, masked to zero while empty
   always_comb begin
      head         = mem[rd_ptr];
      out_dividend = out_valid ? head.dividend : '0;
      out_divisor  = out_valid ? head.divisor  : '0;
      out_dz       = out_valid && head.dz;
      out_ovf      = out_valid && head.ovf;
   end

endmodule

// File: tb/tb_div_operand_queue.sv
// Scoreboard bench for div_operand_queue: stimulus pushes hand-computed expected
// entries, a negedge monitor pops and compares whenever the head is consumed.
module tb_div_operand_queue;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_dividend;
   logic [3:0] in_divisor;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_dividend;
   logic [3:0] out_divisor;
   logic       out_dz;
   logic       out_ovf;
   logic [2:0] count;
   logic [7:0] err_cnt;

   typedef struct {
      logic [3:0] dvd;
      logic [3:0] dvs;
      logic       dz;
      logic       ovf;
   } exp_t;

   exp_t sbq[$];
   int   n_total = 0;
   int   n_pass  = 0;

   div_operand_queue #(.DEPTH(4), .W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_dividend(in_dividend), .in_divisor(in_divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_dividend(out_dividend), .out_divisor(out_divisor),
      .out_dz(out_dz), .out_ovf(out_ovf),
      .count(count), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
      in_valid    = v;
      in_dividend = a;
      in_divisor  = b;
   endtask

   // Record the entry expected at the output; dropped pairs never appear there
   task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input logic dz, input logic ovf);
      exp_t e;
      e.dvd = a; e.dvs = b; e.dz = dz; e.ovf = ovf;
`ifdef DIV_ZERO_DROP_EN
      if (!dz) sbq.push_back(e);
`else
      sbq.push_back(e);
`endif
   endtask

   // Monitor: compare every consumed head, and the zero mask while empty
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pop", 32'(out_dividend), 32'hFFFF_FFFF);
         end else begin
            e = sbq.pop_front();
            chk("pop_dividend", 32'(out_dividend), 32'(e.dvd));
            chk("pop_divisor",  32'(out_divisor),  32'(e.dvs));
            chk("pop_dz",       32'(out_dz),       32'(e.dz));
            chk("pop_ovf",      32'(out_ovf),      32'(e.ovf));
         end
      end else if (!rst && !out_valid) begin
         chk("empty_mask", 32'({out_dividend, out_divisor, out_dz, out_ovf}), 32'd0);
      end
   end

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 4'd0, 4'd0);
      repeat (2) tick();
      rst = 1'b0;

      // reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_err_cnt",   32'(err_cnt),   32'd0);
      chk("rst_out_data",  32'({out_dividend, out_divisor, out_dz, out_ovf}), 32'd0);

      // fill: (5,2) (-7,3) (-8,-1) (6,0)
      drive(1'b1, 4'd5, 4'd2);         push_exp(4'd5, 4'd2, 1'b0, 1'b0);  tick();
      drive(1'b1, 4'(-7), 4'd3);       push_exp(4'(-7), 4'd3, 1'b0, 1'b0); tick();
      drive(1'b1, 4'(-8), 4'(-1));     push_exp(4'(-8), 4'(-1), 1'b0, 1'b1); tick();
      drive(1'b1, 4'd6, 4'd0);         push_exp(4'd6, 4'd0, 1'b1, 1'b0);  tick();
      drive(1'b0, 4'd0, 4'd0);
`ifdef DIV_ZERO_DROP_EN
      chk("fill_count",    32'(count),    32'd3);
      chk("fill_in_ready", 32'(in_ready), 32'd1);
`else
      chk("fill_count",    32'(count),    32'd4);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
`endif
      chk("fill_err_cnt",   32'(err_cnt),      32'd1);
      chk("head_dividend",  32'(out_dividend), 32'd5);
      chk("head_divisor",   32'(out_divisor),  32'd2);
      chk("head_flags",     32'({out_dz, out_ovf}), 32'd0);

      // full queue: offer (1,1) while popping; only the pop happens
      drive(1'b1, 4'd1, 4'd1);
      out_ready = 1'b1;
`ifdef DIV_ZERO_DROP_EN
      push_exp(4'd1, 4'd1, 1'b0, 1'b0);
`endif
      tick();
      drive(1'b0, 4'd0, 4'd0);
      out_ready = 1'b0;
      chk("full_pop_count", 32'(count), 32'd3);
      chk("full_err_cnt",   32'(err_cnt), 32'd1);

      // drain remaining three entries
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      chk("drain_count",  32'(count),      32'd0);
      chk("drain_valid",  32'(out_valid),  32'd0);
      chk("drain_sb",     32'(sbq.size()), 32'd0);

      // sustained push+pop, incrementing dividend, pointers wrap several times
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 4'(i), 4'd3);
         push_exp(4'(i), 4'd3, 1'b0, 1'b0);
         tick();
         chk("stream_count", 32'(count), 32'd1);
      end
      drive(1'b0, 4'd0, 4'd0);
      tick();
      out_ready = 1'b0;
      chk("stream_end_count", 32'(count), 32'd0);

      // mid-stream reset with count=3 and a live handshake offered
      drive(1'b1, 4'd1, 4'd1); push_exp(4'd1, 4'd1, 1'b0, 1'b0); tick();
      drive(1'b1, 4'd2, 4'd1); push_exp(4'd2, 4'd1, 1'b0, 1'b0); tick();
      drive(1'b1, 4'd3, 4'd1); push_exp(4'd3, 4'd1, 1'b0, 1'b0); tick();
      chk("pre_rst_count", 32'(count), 32'd3);
      drive(1'b1, 4'd7, 4'd1);
      out_ready = 1'b1;
      rst = 1'b1;
      sbq.delete();
      tick();
      rst = 1'b0;
      drive(1'b0, 4'd0, 4'd0);
      out_ready = 1'b0;
      chk("mid_rst_count",    32'(count),     32'd0);
      chk("mid_rst_valid",    32'(out_valid), 32'd0);
      chk("mid_rst_err_cnt",  32'(err_cnt),   32'd0);
      chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
      tick();
      chk("mid_rst_lost", 32'(count), 32'd0);

      // 300 zero-divisor pushes while draining: err_cnt saturates
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 4'(i), 4'd0);
         push_exp(4'(i), 4'd0, 1'b1, 1'b0);
         tick();
         if (i == 99) chk("err_cnt_100", 32'(err_cnt), 32'd100);
      end
      chk("err_cnt_sat", 32'(err_cnt), 32'd255);
      drive(1'b0, 4'd0, 4'd0);
      tick();
      out_ready = 1'b0;
      chk("err_cnt_hold", 32'(err_cnt),    32'd255);
      chk("final_count",  32'(count),      32'd0);
      chk("final_sb",     32'(sbq.size()), 32'd0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/div_operand_queue.md
# div_operand_queue

Operand-issue stage directly upstream of the combinational 4-bit signed divider. It accepts (dividend, divisor) pairs over a valid/ready handshake and buffers them in a small FIFO. Each pair is tagged with divide-by-zero and signed-overflow flags at enqueue, and presented to the divider one pair per cycle. Its job is to decouple producers from the divider's consumer and to keep illegal operand pairs from reaching the divider unflagged.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- W, 4, operand width (two's complement)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  producer has a pair
- in_ready  output  1  queue can accept; equals (count != DEPTH)
- in_dividend  input  W  signed dividend
- in_divisor  input  W  signed divisor
- out_valid  output  1  head entry present; equals (count != 0)
- out_ready  input  1  divider side consumes head
- out_dividend  output  W  head dividend; 0 when out_valid=0
- out_divisor  output  W  head divisor; 0 when out_valid=0
- out_dz  output  1  head divisor == 0; 0 when out_valid=0
- out_ovf  output  1  head is most-negative / -1 (-8 / -1 for W=4); 0 when out_valid=0
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- err_cnt  output  8  saturating count of accepted zero-divisor pairs

## Operation
- Push: in_valid && in_ready at the clock edge. The pair and both flags are written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Pop: out_valid && out_ready at the clock edge. rd_ptr advances modulo DEPTH.
- Flags are computed from the input operands at push time and stored alongside the data. They are never recomputed at the head.
- out_ovf applies only when dividend = 1 followed by W-1 zeros and divisor = all ones.
- Storage is first-word-fall-through: the head entry drives the out_* ports combinationally from storage, masked to 0 when the queue is empty.
- Entries leave strictly in order. There is no reordering and no dropping, except under the configuration macro below.
- err_cnt increments by 1 on every push handshake whose divisor is 0, and saturates at 255.
- Pointer wrap: rd_ptr and wr_ptr are each $clog2(DEPTH) bits and wrap naturally. Full and empty are resolved by count, not by pointer comparison.

## Timing
- Reset (rst=1 at an edge) sets: count=0, pointers=0, all storage=0, err_cnt=0.
- Resulting outputs after reset: out_valid=0, out_*=0, in_ready=1.
- rst takes priority over any same-cycle push or pop. A mid-stream reset discards all entries, and no handshake completes in that cycle.
- Latency: a pair pushed at edge N is visible on out_* at cycle N+1 (after the edge). There is no same-cycle bypass from empty.
- Simultaneous push and pop with 0<count<DEPTH: both occur, and count is unchanged.
- Full (count=DEPTH): in_ready=0 even if out_ready=1. There is no combinational path from out_ready to in_ready.
- Empty (count=0): out_valid=0, so out_ready has no effect.
- Throughput: one push and one pop per cycle sustained.
- in_ready and out_valid depend only on registered state.

## Configuration
- DIV_ZERO_DROP_EN defined:
  - A zero-divisor pair completes its handshake (in_ready honoured) but is not written; count and wr_ptr are unchanged.
  - err_cnt still increments.
  - out_dz is tied to 0.
- DIV_ZERO_DROP_EN undefined:
  - Zero-divisor pairs are queued normally with out_dz=1.
  - err_cnt increments identically.

## Test plan
- Reset then idle -> out_valid=0, in_ready=1, count=0, err_cnt=0, all out_* = 0.
- Push (5,2), (-7,3), (-8,-1), (6,0) on consecutive cycles with out_ready=0:
  - count reaches 4, in_ready=0.
  - Head is 5/2 with dz=0 and ovf=0.
  - The third entry pops with ovf=1.
  - err_cnt=1.
  - With DIV_ZERO_DROP_EN, count reaches 3 instead, and (6,0) never appears at the output.
- Full queue, in_valid=1 and out_ready=1 for one cycle -> one pop only, count 4->3, the offered input is not accepted.
- Sustained in_valid=out_ready=1 for 20 cycles with an incrementing dividend -> count steady at 1, outputs in order with 1-cycle latency, pointers wrap cleanly past DEPTH.
- Assert rst with count=3 while in_valid=out_ready=1 -> next cycle count=0, out_valid=0, err_cnt=0, and the entry offered in that cycle is lost.
- 300 consecutive pushes with divisor=0 while draining -> err_cnt saturates at 255 and holds.
